// File: rtl/wb_write_sched.sv
// wb_write_sched -- write-back scheduler for the multicycle MIPS datapath.
//
// The main control unit issues one write-back request per instruction. This
// block sequences the one or two register-file writes for that request.
// POP writes rt and then $sp. Link writes target $31. Each step drives the
// write-register mux select, the write-data mux select and the write enable.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset, returns to IDLE
//   req_valid  in   request present
//   req_op     in   [2:0] write-back opcode
//   req_rt     in   [4:0] instruction[20:16], captured on accept
//   req_rd     in   [4:0] instruction[15:11], captured on accept
//   req_ready  out  request can be accepted this cycle
//   stall      in   register file not ready, freezes the current step
//   wreg_sel   out  [1:0] 00 rt, 01 $29, 10 $31, 11 rd
//   wdata_sel  out  [1:0] 00 ALU, 01 memory, 10 PC+4, 11 SP adjust
//   reg_write  out  register-file write enable
//   wreg_num   out  [4:0] resolved destination register of the current step
//   done       out  one-cycle pulse on the last step of a request
//   busy       out  high whenever not IDLE
//
// Build option:
//   ZERO_REG_GUARD_EN  when defined, reg_write is suppressed for any step
//                      whose destination is $0. Step timing, done and the
//                      selects are unaffected.
module wb_write_sched #(
  parameter logic [4:0] SP_REG = 5'd29,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic [4:0] req_rt,
  input  logic [4:0] req_rd,
  output logic       req_ready,
  input  logic       stall,
  output logic [1:0] wreg_sel,
  output logic [1:0] wdata_sel,
  output logic       reg_write,
  output logic [4:0] wreg_num,
  output logic       done,
  output logic       busy
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_POP = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    STEP1 = 2'b01,
    STEP2 = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] op_p1;
  logic [4:0] rt_p1, rd_p1;

  logic       we_raw;
  logic       last_step;
  logic       accept;
  logic       guard_ok;

  // Returns {wreg_sel, wdata_sel} for a given opcode and step.
  function automatic logic [3:0] step_sel(input logic [2:0] op, input logic second);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      3'b000: s = 4'b0000;
      3'b001: s = 4'b0000;
      3'b010: s = 4'b0001;
      3'b011: s = 4'b1100;
      3'b100: s = 4'b1010;
      3'b101: s = 4'b0111;
      3'b110: s = second ? 4'b0111 : 4'b0001;
      3'b111: s = 4'b1110;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Step outputs decoded from the registered state and captured opcode
  always_comb begin
    wreg_sel  = 2'b00;
    wdata_sel = 2'b00;
    we_raw    = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    case (state)
      STEP1: begin
        busy                 = 1'b1;
        {wreg_sel, wdata_sel} = step_sel(op_p1, 1'b0);
        we_raw               = (op_p1 != OP_NOP);
        last_step            = (op_p1 != OP_POP);
      end
      STEP2: begin
        busy                 = 1'b1;
        {wreg_sel, wdata_sel} = step_sel(op_p1, 1'b1);
        we_raw               = 1'b1;
        last_step            = 1'b1;
      end
      default: ;
    endcase
  end

  // Idle must report register 0, so the mux is gated by busy.
  always_comb begin
    wreg_num = 5'd0;
    if (busy) begin
      case (wreg_sel)
        2'b00:   wreg_num = rt_p1;
        2'b01:   wreg_num = SP_REG;
        2'b10:   wreg_num = RA_REG;
        default: wreg_num = rd_p1;
      endcase
    end
  end

`ifdef ZERO_REG_GUARD_EN
  assign guard_ok = (wreg_num != 5'd0);
`else
  assign guard_ok = 1'b1;
`endif

  // Stall gates the enable and done combinationally; the selects stay put.
  assign reg_write = we_raw & ~stall & guard_ok;
  assign done      = last_step & ~stall;
  assign req_ready = (state == IDLE) | done;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = STEP1;
      STEP1, STEP2: begin
        if (!stall) begin
          if (!last_step)  state_nxt = STEP2;
          else if (accept) state_nxt = STEP1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture / state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_p1 <= 3'd0;
      rt_p1 <= 5'd0;
      rd_p1 <= 5'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_p1 <= req_op;
        rt_p1 <= req_rt;
        rd_p1 <= req_rd;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_sched.sv
module tb_wb_write_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_op;
  logic [4:0] req_rt, req_rd;
  logic       req_ready;
  logic       stall;
  logic [1:0] wreg_sel, wdata_sel;
  logic       reg_write;
  logic [4:0] wreg_num;
  logic       done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  wb_write_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rt(req_rt), .req_rd(req_rd), .req_ready(req_ready), .stall(stall),
    .wreg_sel(wreg_sel), .wdata_sel(wdata_sel), .reg_write(reg_write),
    .wreg_num(wreg_num), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending write steps. The head is the step
  // presented this cycle; it retires on any edge without stall.
  typedef struct {
    logic [1:0] ws;
    logic [1:0] ds;
    logic [4:0] num;
    logic       we;
    logic       last;
  } step_t;

  step_t q[$];

  function automatic logic [4:0] dest(input logic [1:0] ws, input logic [4:0] rt, input logic [4:0] rd);
    case (ws)
      2'b00:   return rt;
      2'b01:   return 5'd29;
      2'b10:   return 5'd31;
      default: return rd;
    endcase
  endfunction

  function automatic step_t mk(input logic [1:0] ws, input logic [1:0] ds, input logic we,
                               input logic last, input logic [4:0] rt, input logic [4:0] rd);
    step_t s;
    s.ws = ws; s.ds = ds; s.we = we; s.last = last;
    s.num = dest(ws, rt, rd);
    return s;
  endfunction

  task automatic push_req(input logic [2:0] op, input logic [4:0] rt, input logic [4:0] rd);
    case (op)
      3'd0: q.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, rt, rd));
      3'd1: q.push_back(mk(2'b00, 2'b00, 1'b1, 1'b1, rt, rd));
      3'd2: q.push_back(mk(2'b00, 2'b01, 1'b1, 1'b1, rt, rd));
      3'd3: q.push_back(mk(2'b11, 2'b00, 1'b1, 1'b1, rt, rd));
      3'd4: q.push_back(mk(2'b10, 2'b10, 1'b1, 1'b1, rt, rd));
      3'd5: q.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1, rt, rd));
      3'd6: begin
        q.push_back(mk(2'b00, 2'b01, 1'b1, 1'b0, rt, rd));
        q.push_back(mk(2'b01, 2'b11, 1'b1, 1'b1, rt, rd));
      end
      default: q.push_back(mk(2'b11, 2'b10, 1'b1, 1'b1, rt, rd));
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare after settling,
  // then advance the model to what the next rising edge will do.
  task automatic cycle(input logic rv, input logic [2:0] op, input logic [4:0] rt,
                       input logic [4:0] rd, input logic st, input logic rst);
    logic [1:0] e_ws, e_ds;
    logic [4:0] e_num;
    logic       e_we, e_done, e_ready, e_busy;
    @(negedge clk);
    req_valid = rv; req_op = op; req_rt = rt; req_rd = rd; stall = st; reset = rst;
    #1;
    if (q.size() == 0) begin
      e_ws = 0; e_ds = 0; e_num = 0; e_we = 0; e_done = 0; e_ready = 1; e_busy = 0;
    end else begin
      e_ws = q[0].ws; e_ds = q[0].ds; e_num = q[0].num;
      e_we = q[0].we & ~st;
`ifdef ZERO_REG_GUARD_EN
      if (e_num == 5'd0) e_we = 1'b0;
`endif
      e_done = q[0].last & ~st;
      e_ready = e_done; e_busy = 1'b1;
    end
    chk("wreg_sel", wreg_sel, e_ws);
    chk("wdata_sel", wdata_sel, e_ds);
    chk("wreg_num", wreg_num, e_num);
    chk("reg_write", reg_write, e_we);
    chk("done", done, e_done);
    chk("req_ready", req_ready, e_ready);
    chk("busy", busy, e_busy);
    if (rst) q.delete();
    else begin
      if (q.size() != 0 && !st) void'(q.pop_front());
      if (rv && e_ready) push_req(op, rt, rd);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_op = 0; req_rt = 0; req_rd = 0; stall = 0;

    // Reset state
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);

    // WR_RD_ALU rd=5
    cycle(1, 3'd3, 5'd9, 5'd5, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rdalu_sel", {wreg_sel, wdata_sel}, 4'b1100);
    chk("rdalu_num", wreg_num, 5);
    chk("rdalu_we", reg_write, 1);
    chk("rdalu_done", done, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rdalu_idle", busy, 0);

    // POP rt=8
    cycle(1, 3'd6, 5'd8, 5'd2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pop1_sel", {wreg_sel, wdata_sel}, 4'b0001);
    chk("pop1_num", wreg_num, 8);
    chk("pop1_done", done, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("pop2_sel", {wreg_sel, wdata_sel}, 4'b0111);
    chk("pop2_num", wreg_num, 29);
    chk("pop2_done", done, 1);

    // Back-to-back LINK31 then WR_RT_ALU rt=3
    cycle(1, 3'd4, 5'd1, 5'd1, 0, 0);
    cycle(1, 3'd1, 5'd3, 5'd7, 0, 0);
    chk("b2b_num0", wreg_num, 31);
    chk("b2b_done0", done, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("b2b_num1", wreg_num, 3);
    chk("b2b_we1", reg_write, 1);
    chk("b2b_done1", done, 1);

    // POP with 3 stalled cycles in STEP2
    cycle(1, 3'd6, 5'd12, 5'd0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      chk("stall_num", wreg_num, 29);
      chk("stall_we", reg_write, 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    chk("stall_rel_we", reg_write, 1);
    chk("stall_rel_done", done, 1);

    // WR_RT_MEM to $0
    cycle(1, 3'd2, 5'd0, 5'd4, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
`ifdef ZERO_REG_GUARD_EN
    chk("zero_we", reg_write, 0);
`else
    chk("zero_we", reg_write, 1);
`endif
    chk("zero_num", wreg_num, 0);
    chk("zero_done", done, 1);

    // Reset held 2 cycles mid-POP, with stall and a competing request
    cycle(1, 3'd6, 5'd8, 5'd1, 0, 0);
    cycle(1, 3'd1, 5'd2, 5'd1, 1, 1);
    cycle(1, 3'd1, 5'd2, 5'd1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", req_ready, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) != 0, 3'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            5'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_write_sched.md
# wb_write_sched

Write-back scheduler for the multicycle MIPS datapath. It accepts write-back requests from the main control unit and sequences one or two register-file writes per request. Each write step drives the write-register mux select, the write-data mux select and the register-file write enable. Multi-write instructions (POP: rt then $sp) and link writes ($31) are sequenced here, so the main FSM issues a single request.

## Interface
Parameters:
- SP_REG, 29: stack-pointer register number, reported on wreg_num.
- RA_REG, 31: link register number, reported on wreg_num.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- req_valid  in  1  request present.
- req_op  in  3  write-back opcode (see Operation).
- req_rt  in  5  instruction[20:16], captured on accept.
- req_rd  in  5  instruction[15:11], captured on accept.
- req_ready  out  1  block can accept a request this cycle.
- stall  in  1  register file not ready; freezes the current write step.
- wreg_sel  out  2  write-register mux select: 00 rt, 01 $29, 10 $31, 11 rd.
- wdata_sel  out  2  write-data mux select: 00 ALU result, 01 memory data, 10 PC+4, 11 SP adjust.
- reg_write  out  1  register-file write enable.
- wreg_num  out  5  resolved destination register of the current step.
- done  out  1  one-cycle pulse on the last step of a request.
- busy  out  1  high in any non-IDLE state.

## Operation
Opcodes (step1 / step2, as wreg_sel,wdata_sel):
- 000 NOP: step1 only; no reg_write, wreg_sel 00, wdata_sel 00.
- 001 WR_RT_ALU: 00,00.
- 010 WR_RT_MEM: 00,01.
- 011 WR_RD_ALU: 11,00.
- 100 LINK31: 10,10.
- 101 SP_ADJ: 01,11.
- 110 POP: step1 00,01; step2 01,11.
- 111 JALR_RD: 11,10.

States:
- IDLE: outputs idle, req_ready=1. On accept (req_valid & req_ready), capture op/rt/rd and go to STEP1.
- STEP1: drive the step-1 selects. reg_write = !stall (except NOP). If stall, hold. Otherwise go to STEP2 for POP; for all other ops, this is the last step.
- STEP2: drive the step-2 selects. reg_write = !stall. If stall, hold. Otherwise this is the last step.
- Last step with !stall: done=1. If a request is accepted in the same cycle, go to STEP1 with the new captured fields; otherwise go to IDLE.

Signal rules:
- req_ready = IDLE, or (last step & !stall). This gives back-to-back single-write ops at one per cycle.
- wreg_num: rt, SP_REG, RA_REG or rd, per wreg_sel.
- Idle output values: wreg_sel=00, wdata_sel=00, reg_write=0, wreg_num=0, done=0, busy=0.

## Timing
- Reset values: all outputs 0 except req_ready=1; state IDLE; captured fields 0.
- Accept on edge N; step-1 outputs valid in cycle N+1 (selects registered, reg_write gated combinationally by stall).
- Single-write latency: accept to write is 1 cycle. POP writes in N+1 and N+2 when not stalled.
- Stall: holds the state, selects and wreg_num; reg_write and done are forced to 0 while stall=1.
- Reset asserted mid-request (including during stall): IDLE on the next edge, with no done for the abandoned request. Reset wins over a simultaneous accept.
- req_valid with req_ready=0: the request is ignored. The requester must hold it.
- Inputs req_rt/req_rd are only sampled on accept; later changes have no effect on an in-flight request.

## Configuration
- ZERO_REG_GUARD_EN defined: when wreg_num==0 in a step, reg_write is forced to 0. Step timing, done and selects are unchanged.
- Not defined: reg_write is driven as specified regardless of the destination. The register file is responsible for ignoring writes to $0.

## Test plan
- Reset: hold reset 2 cycles mid-POP (state STEP1) -> next cycle IDLE, reg_write=0, done=0, req_ready=1, busy=0.
- WR_RD_ALU with rd=5, accepted at N -> cycle N+1: wreg_sel=11, wdata_sel=00, wreg_num=5, reg_write=1, done=1; IDLE at N+2.
- POP with rt=8 -> N+1: wreg_sel=00, wdata_sel=01, wreg_num=8, reg_write=1, done=0; N+2: wreg_sel=01, wdata_sel=11, wreg_num=29, reg_write=1, done=1.
- Back-to-back LINK31 then WR_RT_ALU (rt=3), req_valid held -> writes to 31 then 3 in consecutive cycles, done high both cycles.
- POP with stall=1 for 3 cycles in STEP2 -> wreg_num=29 held, reg_write=0 for 3 cycles, then one cycle reg_write=1 with done=1.
- WR_RT_MEM with rt=0 -> with ZERO_REG_GUARD_EN: reg_write=0, done=1; without it: reg_write=1, wreg_num=0.
